// File: rtl/subcarrier_rx.sv
// Backscatter subcarrier detector: measures the spacing of sliced-envelope rising
// edges, classifies 40/80-class tags, tracks lock and reports each finished burst.
module subcarrier_rx #(
    parameter int unsigned P40_MIN = 270,
    parameter int unsigned P40_MAX = 330,
    parameter int unsigned P80_MIN = 135,
    parameter int unsigned P80_MAX = 165,
    parameter int unsigned LOCK_N  = 4,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned PW      = 12
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        sc_in_i,
    output logic        sc_valid_o,
    output logic [1:0]  sc_class_o,
    output logic        burst_done_o,
    output logic [1:0]  burst_class_o,
    output logic [15:0] burst_len_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    localparam logic [1:0]    CLS_NONE   = 2'd0;
    localparam logic [1:0]    CLS_40     = 2'd1;
    localparam logic [1:0]    CLS_80     = 2'd2;
    localparam logic [PW:0]   P40_MIN_C  = (PW+1)'(P40_MIN);
    localparam logic [PW:0]   P40_MAX_C  = (PW+1)'(P40_MAX);
    localparam logic [PW:0]   P80_MIN_C  = (PW+1)'(P80_MIN);
    localparam logic [PW:0]   P80_MAX_C  = (PW+1)'(P80_MAX);
    localparam logic [PW:0]   TIMEOUT_C  = (PW+1)'(TIMEOUT);
    localparam logic [3:0]    LOCK_N_C   = 4'(LOCK_N);
    localparam logic [15:0]   LOCK_LEN_C = 16'(LOCK_N);
    localparam logic [PW-1:0] CNT_MAX_C  = {PW{1'b1}};
    localparam logic [15:0]   LEN_MAX_C  = 16'hFFFF;

    function automatic logic [1:0] classify(input logic [PW:0] period);
        logic [1:0] cls;
        if ((period >= P40_MIN_C) && (period <= P40_MAX_C)) begin
            cls = CLS_40;
        end else if ((period >= P80_MIN_C) && (period <= P80_MAX_C)) begin
            cls = CLS_80;
        end else begin
            cls = CLS_NONE;
        end
        return cls;
    endfunction

    logic          sync1_q;
    logic          sync2_q;
    logic          prev_q;
    logic          edge_p_q;
    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;
    logic [PW:0]   period_s;
    logic [1:0]    class_s;
    logic          timeout_s;
    logic [3:0]    acq_match_s;
    logic          lock_hit_s;
    state_e        state_q;
    state_e        state_d;
    logic [1:0]    cand_q;
    logic [1:0]    cand_d;
    logic [3:0]    match_q;
    logic [3:0]    match_d;
    logic [15:0]   len_q;
    logic [15:0]   len_d;
    logic          sc_valid_q;
    logic          sc_valid_d;
    logic [1:0]    sc_class_q;
    logic [1:0]    sc_class_d;
    logic          burst_done_q;
    logic          burst_done_d;
    logic [1:0]    burst_class_q;
    logic [1:0]    burst_class_d;
    logic [15:0]   burst_len_q;
    logic [15:0]   burst_len_d;

    // Two-flop synchronizer followed by a registered rising-edge detector.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            edge_p_q <= 1'b0;
        end else begin
            sync1_q  <= sc_in_i;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            edge_p_q <= sync2_q & ~prev_q;
        end
    end

    // Period counter: restarts on each edge, holds at full scale.
    always_comb begin
        if (edge_p_q) begin
            cnt_d = {PW{1'b0}};
        end else if (cnt_q == CNT_MAX_C) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + PW'(1);
        end
    end

    // Period counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= {PW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The counter lags by one, so the cycles since the last edge are cnt_q + 1.
    always_comb begin
        period_s  = {1'b0, cnt_q} + (PW+1)'(1);
        class_s   = classify(period_s);
        timeout_s = (state_q != ST_IDLE) && (period_s == TIMEOUT_C);
        if (class_s == CLS_NONE) begin
            acq_match_s = 4'd0;
        end else if (class_s == cand_q) begin
            acq_match_s = match_q + 4'd1;
        end else begin
            acq_match_s = 4'd1;
        end
        lock_hit_s = (acq_match_s == LOCK_N_C);
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a timeout outranks a coincident edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (edge_p_q) begin
                    state_d = ST_ACQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACQ: begin
                if (timeout_s) begin
                    state_d = ST_IDLE;
                end else if (edge_p_q && lock_hit_s) begin
                    state_d = ST_LOCKED;
                end else begin
                    state_d = ST_ACQ;
                end
            end
            ST_LOCKED: begin
                if (timeout_s) begin
                    state_d = ST_IDLE;
                end else if (edge_p_q && (class_s != sc_class_q)) begin
                    state_d = ST_ACQ;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: acquisition bookkeeping, lock status and burst reporting.
    always_comb begin
        cand_d        = cand_q;
        match_d       = match_q;
        len_d         = len_q;
        sc_valid_d    = sc_valid_q;
        sc_class_d    = sc_class_q;
        burst_done_d  = 1'b0;
        burst_class_d = burst_class_q;
        burst_len_d   = burst_len_q;
        case (state_q)
            ST_IDLE: begin
                if (edge_p_q) begin
                    cand_d  = CLS_NONE;
                    match_d = 4'd0;
                end else begin
                    cand_d  = cand_q;
                    match_d = match_q;
                end
            end
            ST_ACQ: begin
                if (timeout_s) begin
                    cand_d  = CLS_NONE;
                    match_d = 4'd0;
                end else if (edge_p_q) begin
                    cand_d  = class_s;
                    match_d = acq_match_s;
                    if (lock_hit_s) begin
                        sc_valid_d = 1'b1;
                        sc_class_d = class_s;
                        len_d      = LOCK_LEN_C;
                    end else begin
                        sc_valid_d = 1'b0;
                        sc_class_d = CLS_NONE;
                    end
                end else begin
                    cand_d  = cand_q;
                    match_d = match_q;
                end
            end
            ST_LOCKED: begin
                if (timeout_s || (edge_p_q && (class_s != sc_class_q))) begin
                    burst_done_d  = 1'b1;
                    burst_class_d = sc_class_q;
                    burst_len_d   = len_q;
                    sc_valid_d    = 1'b0;
                    sc_class_d    = CLS_NONE;
                    cand_d        = CLS_NONE;
                    match_d       = 4'd0;
                end else if (edge_p_q) begin
                    if (len_q == LEN_MAX_C) begin
                        len_d = len_q;
                    end else begin
                        len_d = len_q + 16'd1;
                    end
                end else begin
                    len_d = len_q;
                end
            end
            default: begin
                cand_d     = CLS_NONE;
                match_d    = 4'd0;
                sc_valid_d = 1'b0;
                sc_class_d = CLS_NONE;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cand_q        <= CLS_NONE;
            match_q       <= 4'd0;
            len_q         <= 16'd0;
            sc_valid_q    <= 1'b0;
            sc_class_q    <= CLS_NONE;
            burst_done_q  <= 1'b0;
            burst_class_q <= CLS_NONE;
            burst_len_q   <= 16'd0;
        end else begin
            cand_q        <= cand_d;
            match_q       <= match_d;
            len_q         <= len_d;
            sc_valid_q    <= sc_valid_d;
            sc_class_q    <= sc_class_d;
            burst_done_q  <= burst_done_d;
            burst_class_q <= burst_class_d;
            burst_len_q   <= burst_len_d;
        end
    end

    assign sc_valid_o    = sc_valid_q;
    assign sc_class_o    = sc_class_q;
    assign burst_done_o  = burst_done_q;
    assign burst_class_o = burst_class_q;
    assign burst_len_o   = burst_len_q;

endmodule

// File: tb/tb_subcarrier_rx.sv
// Directed bench for subcarrier_rx: edge trains with hand-computed lock and
// burst timing (edge_p lands 3 cycles after a rise, outputs one cycle later).
module tb_subcarrier_rx;

    localparam int TIMEOUT = 1024;
    localparam int HI      = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sc_in = 1'b0;
    logic        sc_valid;
    logic [1:0]  sc_class;
    logic        burst_done;
    logic [1:0]  burst_class;
    logic [15:0] burst_len;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    int edge_cyc [32];
    int ne;
    int bd_cnt;
    int bd_cyc [8];
    int bd_cls [8];
    int bd_len [8];
    int bd_vld [8];
    int v_cnt;
    int v_cyc [8];
    int v_cls [8];
    logic valid_prev;

    int lock_p [4] = '{270, 330, 135, 165};
    int lock_c [4] = '{1, 1, 2, 2};
    int bad_p  [5] = '{269, 331, 134, 166, 200};

    subcarrier_rx dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .sc_in_i       (sc_in),
        .sc_valid_o    (sc_valid),
        .sc_class_o    (sc_class),
        .burst_done_o  (burst_done),
        .burst_class_o (burst_class),
        .burst_len_o   (burst_len)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log burst_done pulses and sc_valid rising edges with their cycle stamps.
    always @(negedge clk) begin
        if (burst_done === 1'b1) begin
            if (bd_cnt < 8) begin
                bd_cyc[bd_cnt] = cyc;
                bd_cls[bd_cnt] = int'(burst_class);
                bd_len[bd_cnt] = int'(burst_len);
                bd_vld[bd_cnt] = (sc_valid === 1'b1) ? 1 : 0;
            end
            bd_cnt++;
        end
        if ((sc_valid === 1'b1) && (valid_prev !== 1'b1)) begin
            if (v_cnt < 8) begin
                v_cyc[v_cnt] = cyc;
                v_cls[v_cnt] = int'(sc_class);
            end
            v_cnt++;
        end
        valid_prev = sc_valid;
    end

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        ne     = 0;
        bd_cnt = 0;
        v_cnt  = 0;
    endtask

    task automatic send_train(input int n, input int period);
        for (int i = 0; i < n; i++) begin
            sc_in = 1'b1;
            edge_cyc[ne] = cyc;
            ne++;
            step(HI);
            sc_in = 1'b0;
            step(period - HI);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sc_in = 1'b0;
        clear_log();
        step(3);
        rst = 1'b0;
        n_cmp++; if (sc_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %0d want 0", sc_valid); end
        n_cmp++; if (sc_class !== 2'd0) begin n_bad++; $display("FAIL rst_class: got %0d want 0", sc_class); end
        n_cmp++; if (burst_done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %0d want 0", burst_done); end
        n_cmp++; if (burst_class !== 2'd0) begin n_bad++; $display("FAIL rst_bclass: got %0d want 0", burst_class); end
        n_cmp++; if (burst_len !== 16'd0) begin n_bad++; $display("FAIL rst_blen: got %0d want 0", burst_len); end
    endtask

    task automatic test_lock_40();
        clear_log();
        send_train(11, 300);
        step(TIMEOUT);
        n_cmp++; if (v_cnt !== 1) begin n_bad++; $display("FAIL l40_vcnt: got %0d want 1", v_cnt); end
        n_cmp++; if (v_cyc[0] !== edge_cyc[4] + 4) begin n_bad++; $display("FAIL l40_vcyc: got %0d want %0d", v_cyc[0], edge_cyc[4] + 4); end
        n_cmp++; if (v_cls[0] !== 1) begin n_bad++; $display("FAIL l40_vcls: got %0d want 1", v_cls[0]); end
        n_cmp++; if (bd_cnt !== 1) begin n_bad++; $display("FAIL l40_bdcnt: got %0d want 1", bd_cnt); end
        n_cmp++; if (bd_cyc[0] !== edge_cyc[10] + 4 + TIMEOUT) begin n_bad++; $display("FAIL l40_bdcyc: got %0d want %0d", bd_cyc[0], edge_cyc[10] + 4 + TIMEOUT); end
        n_cmp++; if (bd_cls[0] !== 1) begin n_bad++; $display("FAIL l40_bdcls: got %0d want 1", bd_cls[0]); end
        n_cmp++; if (bd_len[0] !== 10) begin n_bad++; $display("FAIL l40_bdlen: got %0d want 10", bd_len[0]); end
        n_cmp++; if (bd_vld[0] !== 0) begin n_bad++; $display("FAIL l40_bdvld: got %0d want 0", bd_vld[0]); end
        n_cmp++; if (burst_len !== 16'd10) begin n_bad++; $display("FAIL l40_hold: got %0d want 10", burst_len); end
    endtask

    task automatic test_lock_80();
        clear_log();
        send_train(8, 150);
        step(TIMEOUT);
        n_cmp++; if (v_cyc[0] !== edge_cyc[4] + 4) begin n_bad++; $display("FAIL l80_vcyc: got %0d want %0d", v_cyc[0], edge_cyc[4] + 4); end
        n_cmp++; if (v_cls[0] !== 2) begin n_bad++; $display("FAIL l80_vcls: got %0d want 2", v_cls[0]); end
        n_cmp++; if (bd_cnt !== 1) begin n_bad++; $display("FAIL l80_bdcnt: got %0d want 1", bd_cnt); end
        n_cmp++; if (bd_cls[0] !== 2) begin n_bad++; $display("FAIL l80_bdcls: got %0d want 2", bd_cls[0]); end
        n_cmp++; if (bd_len[0] !== 7) begin n_bad++; $display("FAIL l80_bdlen: got %0d want 7", bd_len[0]); end
    endtask

    task automatic test_class_change();
        clear_log();
        send_train(5, 300);
        send_train(7, 150);
        step(TIMEOUT);
        n_cmp++; if (bd_cnt !== 2) begin n_bad++; $display("FAIL chg_bdcnt: got %0d want 2", bd_cnt); end
        n_cmp++; if (bd_cyc[0] !== edge_cyc[6] + 4) begin n_bad++; $display("FAIL chg_bdcyc: got %0d want %0d", bd_cyc[0], edge_cyc[6] + 4); end
        n_cmp++; if (bd_cls[0] !== 1) begin n_bad++; $display("FAIL chg_bdcls: got %0d want 1", bd_cls[0]); end
        n_cmp++; if (bd_len[0] !== 5) begin n_bad++; $display("FAIL chg_bdlen: got %0d want 5", bd_len[0]); end
        n_cmp++; if (bd_vld[0] !== 0) begin n_bad++; $display("FAIL chg_bdvld: got %0d want 0", bd_vld[0]); end
        n_cmp++; if (v_cnt !== 2) begin n_bad++; $display("FAIL chg_vcnt: got %0d want 2", v_cnt); end
        n_cmp++; if (v_cyc[1] !== edge_cyc[10] + 4) begin n_bad++; $display("FAIL chg_relock: got %0d want %0d", v_cyc[1], edge_cyc[10] + 4); end
        n_cmp++; if (v_cls[1] !== 2) begin n_bad++; $display("FAIL chg_vcls: got %0d want 2", v_cls[1]); end
        n_cmp++; if (bd_cls[1] !== 2) begin n_bad++; $display("FAIL chg_bdcls2: got %0d want 2", bd_cls[1]); end
        n_cmp++; if (bd_len[1] !== 5) begin n_bad++; $display("FAIL chg_bdlen2: got %0d want 5", bd_len[1]); end
    endtask

    task automatic test_windows();
        for (int k = 0; k < 4; k++) begin
            clear_log();
            send_train(5, lock_p[k]);
            step(TIMEOUT);
            n_cmp++; if (v_cnt !== 1) begin n_bad++; $display("FAIL win_lock_p%0d: vcnt got %0d want 1", lock_p[k], v_cnt); end
            n_cmp++; if (v_cls[0] !== lock_c[k]) begin n_bad++; $display("FAIL win_cls_p%0d: got %0d want %0d", lock_p[k], v_cls[0], lock_c[k]); end
            n_cmp++; if (bd_len[0] !== 4) begin n_bad++; $display("FAIL win_len_p%0d: got %0d want 4", lock_p[k], bd_len[0]); end
        end
        for (int k = 0; k < 5; k++) begin
            clear_log();
            send_train(6, bad_p[k]);
            step(TIMEOUT);
            n_cmp++; if (v_cnt !== 0) begin n_bad++; $display("FAIL win_nolock_p%0d: vcnt got %0d want 0", bad_p[k], v_cnt); end
            n_cmp++; if (bd_cnt !== 0) begin n_bad++; $display("FAIL win_nodone_p%0d: got %0d want 0", bad_p[k], bd_cnt); end
        end
        clear_log();
        for (int k = 0; k < 5; k++) begin
            send_train(1, 300);
            send_train(1, 150);
        end
        step(TIMEOUT);
        n_cmp++; if (v_cnt !== 0) begin n_bad++; $display("FAIL alt_nolock: vcnt got %0d want 0", v_cnt); end
        n_cmp++; if (bd_cnt !== 0) begin n_bad++; $display("FAIL alt_nodone: got %0d want 0", bd_cnt); end
    endtask

    task automatic test_reset_locked();
        clear_log();
        send_train(7, 300);
        n_cmp++; if (sc_valid !== 1'b1) begin n_bad++; $display("FAIL rl_prelock: got %0d want 1", sc_valid); end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        n_cmp++; if (sc_valid !== 1'b0) begin n_bad++; $display("FAIL rl_valid: got %0d want 0", sc_valid); end
        n_cmp++; if (sc_class !== 2'd0) begin n_bad++; $display("FAIL rl_class: got %0d want 0", sc_class); end
        n_cmp++; if (burst_done !== 1'b0) begin n_bad++; $display("FAIL rl_done: got %0d want 0", burst_done); end
        n_cmp++; if (burst_class !== 2'd0) begin n_bad++; $display("FAIL rl_bclass: got %0d want 0", burst_class); end
        n_cmp++; if (burst_len !== 16'd0) begin n_bad++; $display("FAIL rl_blen: got %0d want 0", burst_len); end
        step(TIMEOUT + 16);
        n_cmp++; if (bd_cnt !== 0) begin n_bad++; $display("FAIL rl_nodone: got %0d want 0", bd_cnt); end
        clear_log();
        send_train(5, 300);
        step(TIMEOUT);
        n_cmp++; if (v_cyc[0] !== edge_cyc[4] + 4) begin n_bad++; $display("FAIL rl_relock: got %0d want %0d", v_cyc[0], edge_cyc[4] + 4); end
        n_cmp++; if (bd_len[0] !== 4) begin n_bad++; $display("FAIL rl_bdlen: got %0d want 4", bd_len[0]); end
    endtask

    task automatic test_exact_timeout();
        clear_log();
        send_train(4, 300);
        send_train(1, TIMEOUT);
        send_train(6, 300);
        step(TIMEOUT);
        n_cmp++; if (v_cyc[0] !== edge_cyc[4] + 4) begin n_bad++; $display("FAIL et_lock: got %0d want %0d", v_cyc[0], edge_cyc[4] + 4); end
        n_cmp++; if (bd_cnt !== 2) begin n_bad++; $display("FAIL et_bdcnt: got %0d want 2", bd_cnt); end
        n_cmp++; if (bd_cyc[0] !== edge_cyc[4] + 4 + TIMEOUT) begin n_bad++; $display("FAIL et_bdcyc: got %0d want %0d", bd_cyc[0], edge_cyc[4] + 4 + TIMEOUT); end
        n_cmp++; if (bd_len[0] !== 4) begin n_bad++; $display("FAIL et_bdlen: got %0d want 4", bd_len[0]); end
        n_cmp++; if (bd_cls[0] !== 1) begin n_bad++; $display("FAIL et_bdcls: got %0d want 1", bd_cls[0]); end
        n_cmp++; if (v_cnt !== 2) begin n_bad++; $display("FAIL et_vcnt: got %0d want 2", v_cnt); end
        n_cmp++; if (v_cyc[1] !== edge_cyc[10] + 4) begin n_bad++; $display("FAIL et_rearm: got %0d want %0d", v_cyc[1], edge_cyc[10] + 4); end
    endtask

    initial begin
        test_reset();
        test_lock_40();
        test_lock_80();
        test_class_change();
        test_windows();
        test_reset_locked();
        test_exact_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
